// File: rtl/uart_rx_cfg_ctrl.sv
// UART receiver configuration/status controller: frame-boundary config commit and saturating counters.
// Define UART_RX_ERR_CNT_EN to build the parity/stop error counters; otherwise they read as 0.
module uart_rx_cfg_ctrl #(
  parameter int PRESCALE_W   = 6,
  parameter int CNT_W        = 8,
  parameter int PRESCALE_RST = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_wr,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic                  cfg_par_en,
  input  logic                  cfg_par_typ,
  input  logic                  rx_busy,
  input  logic                  rx_data_valid,
  input  logic                  rx_par_err,
  input  logic                  rx_stop_err,
  input  logic                  clr_cnt,
  output logic [PRESCALE_W-1:0] Prescale,
  output logic                  PAR_EN,
  output logic                  PAR_TYP,
  output logic                  rx_enable,
  output logic                  cfg_busy,
  output logic                  cfg_done,
  output logic                  cfg_err,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic [CNT_W-1:0]      par_err_cnt,
  output logic [CNT_W-1:0]      stop_err_cnt
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_QUIESCE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  qcnt_q, qcnt_d;
  logic [PRESCALE_W-1:0] pend_pres_q, pend_pres_d;
  logic                  pend_pen_q, pend_pen_d;
  logic                  pend_ptyp_q, pend_ptyp_d;
  logic [PRESCALE_W-1:0] pres_q, pres_d;
  logic                  pen_q, pen_d;
  logic                  ptyp_q, ptyp_d;
  logic                  rx_en_q, rx_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  legal;

  assign legal = (cfg_prescale == PRESCALE_W'(8)) ||
                 (cfg_prescale == PRESCALE_W'(16)) ||
                 (cfg_prescale == PRESCALE_W'(32));

  always_comb begin
    state_d     = state_q;
    qcnt_d      = qcnt_q;
    pend_pres_d = pend_pres_q;
    pend_pen_d  = pend_pen_q;
    pend_ptyp_d = pend_ptyp_q;
    pres_d      = pres_q;
    pen_d       = pen_q;
    ptyp_d      = ptyp_q;
    rx_en_d     = rx_en_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_RUN, ST_WAIT: begin
        if (cfg_wr) begin
          if (legal) begin
            pend_pres_d = cfg_prescale;
            pend_pen_d  = cfg_par_en;
            pend_ptyp_d = cfg_par_typ;
            if (state_q == ST_RUN) state_d = ST_WAIT;
          end else begin
            err_d = 1'b1;
          end
        end
        if (state_q == ST_WAIT && !rx_busy) begin
          state_d = ST_QUIESCE;
          qcnt_d  = 1'b0;
          rx_en_d = 1'b0;
        end
      end
      ST_QUIESCE: begin
        err_d = cfg_wr;
        // Second quiesce edge is the commit edge: apply and re-enable together.
        if (qcnt_q) begin
          pres_d  = pend_pres_q;
          pen_d   = pend_pen_q;
          ptyp_d  = pend_ptyp_q;
          rx_en_d = 1'b1;
          done_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          qcnt_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
    busy_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      qcnt_q      <= 1'b0;
      pend_pres_q <= '0;
      pend_pen_q  <= 1'b0;
      pend_ptyp_q <= 1'b0;
      pres_q      <= PRESCALE_W'(PRESCALE_RST);
      pen_q       <= 1'b1;
      ptyp_q      <= 1'b0;
      rx_en_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      qcnt_q      <= qcnt_d;
      pend_pres_q <= pend_pres_d;
      pend_pen_q  <= pend_pen_d;
      pend_ptyp_q <= pend_ptyp_d;
      pres_q      <= pres_d;
      pen_q       <= pen_d;
      ptyp_q      <= ptyp_d;
      rx_en_q     <= rx_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  logic [CNT_W-1:0] frame_q;

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) frame_q <= '0;
    else if (rx_en_q && rx_data_valid && frame_q != '1) frame_q <= frame_q + 1'b1;
  end

`ifdef UART_RX_ERR_CNT_EN
  logic [CNT_W-1:0] par_q, stop_q;

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      par_q  <= '0;
      stop_q <= '0;
    end else if (rx_en_q) begin
      if (rx_par_err && par_q != '1) par_q <= par_q + 1'b1;
      if (rx_stop_err && stop_q != '1) stop_q <= stop_q + 1'b1;
    end
  end

  assign par_err_cnt  = par_q;
  assign stop_err_cnt = stop_q;
`else
  logic unused_err;
  assign unused_err   = rx_par_err ^ rx_stop_err;
  assign par_err_cnt  = '0;
  assign stop_err_cnt = '0;
`endif

  assign Prescale  = pres_q;
  assign PAR_EN    = pen_q;
  assign PAR_TYP   = ptyp_q;
  assign rx_enable = rx_en_q;
  assign cfg_busy  = busy_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_uart_rx_cfg_ctrl.sv
// Self-checking bench for uart_rx_cfg_ctrl: directed scenarios plus random traffic
// against a transaction-level model of the configuration and counters.
module tb_uart_rx_cfg_ctrl;
   localparam int PW   = 6;
   localparam int CW   = 8;
   localparam int PRST = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst, cfg_wr, cfg_par_en, cfg_par_typ, rx_busy;
   logic rx_data_valid, rx_par_err, rx_stop_err, clr_cnt;
   logic [PW-1:0] cfg_prescale;
   logic [PW-1:0] Prescale;
   logic PAR_EN, PAR_TYP, rx_enable, cfg_busy, cfg_done, cfg_err;
   logic [CW-1:0] frame_cnt, par_err_cnt, stop_err_cnt;

   int nChecks = 0;
   int nErrors = 0;

   // Model of what the controller should present after each edge
   int mPres, mFrame, mPar, mStop;
   bit mPen, mPtyp, mEn, mDone, mErr;
   bit havePending;
   int pendPres;
   bit pendPen, pendPtyp;
   int quiesceLeft;

   always #5 clk = ~clk;

   uart_rx_cfg_ctrl #(.PRESCALE_W(PW), .CNT_W(CW), .PRESCALE_RST(PRST)) dut (
      .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_prescale(cfg_prescale),
      .cfg_par_en(cfg_par_en), .cfg_par_typ(cfg_par_typ), .rx_busy(rx_busy),
      .rx_data_valid(rx_data_valid), .rx_par_err(rx_par_err), .rx_stop_err(rx_stop_err),
      .clr_cnt(clr_cnt), .Prescale(Prescale), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
      .rx_enable(rx_enable), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
      .frame_cnt(frame_cnt), .par_err_cnt(par_err_cnt), .stop_err_cnt(stop_err_cnt)
   );

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic int satInc(input int v, input bit hit);
      return (hit && v < CMAX) ? v + 1 : v;
   endfunction

   // Advances the model by one clock edge using the inputs currently driven
   task automatic modelEdge();
      bit legal;
      legal = (cfg_prescale == 8) || (cfg_prescale == 16) || (cfg_prescale == 32);
      if (rst) begin
         mPres = PRST; mPen = 1; mPtyp = 0; mEn = 1; mDone = 0; mErr = 0;
         havePending = 0; quiesceLeft = 0; mFrame = 0; mPar = 0; mStop = 0;
         return;
      end
      if (clr_cnt) begin
         mFrame = 0; mPar = 0; mStop = 0;
      end else if (mEn) begin
         mFrame = satInc(mFrame, rx_data_valid);
         mPar   = satInc(mPar, rx_par_err);
         mStop  = satInc(mStop, rx_stop_err);
      end
      mDone = 0;
      mErr  = cfg_wr && (!legal || quiesceLeft > 0);
      if (quiesceLeft > 0) begin
         quiesceLeft--;
         if (quiesceLeft == 0) begin
            mPres = pendPres; mPen = pendPen; mPtyp = pendPtyp;
            mEn = 1; mDone = 1; havePending = 0;
         end
      end else begin
         if (cfg_wr && legal) begin
            pendPres = int'(cfg_prescale); pendPen = cfg_par_en; pendPtyp = cfg_par_typ;
         end
         if (havePending && !rx_busy) begin
            quiesceLeft = 2;
            mEn = 0;
         end
         if (cfg_wr && legal) havePending = 1;
      end
   endtask

   task automatic checkAll();
      checkOutput("Prescale", 32'(Prescale), 32'(mPres));
      checkOutput("PAR_EN", 32'(PAR_EN), 32'(mPen));
      checkOutput("PAR_TYP", 32'(PAR_TYP), 32'(mPtyp));
      checkOutput("rx_enable", 32'(rx_enable), 32'(mEn));
      checkOutput("cfg_busy", 32'(cfg_busy), 32'(havePending));
      checkOutput("cfg_done", 32'(cfg_done), 32'(mDone));
      checkOutput("cfg_err", 32'(cfg_err), 32'(mErr));
      checkOutput("frame_cnt", 32'(frame_cnt), 32'(mFrame));
`ifdef UART_RX_ERR_CNT_EN
      checkOutput("par_err_cnt", 32'(par_err_cnt), 32'(mPar));
      checkOutput("stop_err_cnt", 32'(stop_err_cnt), 32'(mStop));
`else
      checkOutput("par_err_cnt", 32'(par_err_cnt), 32'd0);
      checkOutput("stop_err_cnt", 32'(stop_err_cnt), 32'd0);
`endif
   endtask

   // One clock of stimulus: drive at negedge, update model at posedge, check #1 later
   task automatic applyStimulus(input bit r, input bit wr, input int pres, input bit pen,
                                input bit ptyp, input bit busy, input bit dv, input bit pe,
                                input bit se, input bit clr);
      @(negedge clk);
      rst = r; cfg_wr = wr; cfg_prescale = PW'(pres); cfg_par_en = pen; cfg_par_typ = ptyp;
      rx_busy = busy; rx_data_valid = dv; rx_par_err = pe; rx_stop_err = se; clr_cnt = clr;
      @(posedge clk);
      modelEdge();
      #1;
      checkAll();
   endtask

   task automatic idle(input int n, input bit busy);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, busy, 0, 0, 0, 0);
   endtask

   int lowCycles;
   int busyRun;

   initial begin
      rst = 1; cfg_wr = 0; cfg_prescale = '0; cfg_par_en = 0; cfg_par_typ = 0;
      rx_busy = 0; rx_data_valid = 0; rx_par_err = 0; rx_stop_err = 0; clr_cnt = 0;
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("resetPrescale", 32'(Prescale), 32'd8);
      checkOutput("resetParEn", 32'(PAR_EN), 32'd1);

      // Basic write with an idle receiver; enable must drop for exactly two cycles
      applyStimulus(0, 1, 16, 0, 1, 0, 0, 0, 0, 0);
      lowCycles = 0;
      for (int i = 0; i < 4; i++) begin
         idle(1, 0);
         if (!rx_enable) lowCycles++;
         if (i == 2) checkOutput("doneAtK3", 32'(cfg_done), 32'd1);
      end
      checkOutput("enableLowCycles", 32'(lowCycles), 32'd2);
      checkOutput("applied16", 32'(Prescale), 32'd16);

      // Long busy receiver holds the write pending
      applyStimulus(0, 1, 32, 1, 0, 1, 0, 0, 0, 0);
      idle(19, 1);
      checkOutput("heldPrescale", 32'(Prescale), 32'd16);
      idle(4, 0);
      checkOutput("applied32", 32'(Prescale), 32'd32);

      // Illegal prescale
      applyStimulus(0, 1, 12, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("illegalErr", 32'(cfg_err), 32'd1);
      idle(2, 0);

      // Last write wins while waiting for idle
      applyStimulus(0, 1, 16, 1, 1, 1, 0, 0, 0, 0);
      applyStimulus(0, 1, 32, 0, 0, 1, 0, 0, 0, 0);
      idle(4, 0);
      checkOutput("lastWins", 32'(Prescale), 32'd32);

      // Write during quiesce is dropped
      applyStimulus(0, 1, 16, 1, 0, 0, 0, 0, 0, 0);
      idle(1, 0);
      applyStimulus(0, 1, 8, 0, 1, 0, 0, 0, 0, 0);
      checkOutput("quiesceErr", 32'(cfg_err), 32'd1);
      idle(3, 0);
      checkOutput("earlierCommitted", 32'(Prescale), 32'd16);

      // Saturation, then clear against a same-cycle strobe
      for (int i = 0; i < 300; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, i < 5, 0, 0);
      checkOutput("frameSat", 32'(frame_cnt), 32'd255);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
      checkOutput("clrPriority", 32'(par_err_cnt), 32'd0);

      // Reset mid-quiesce discards the pending write
      applyStimulus(0, 1, 32, 0, 1, 0, 0, 0, 0, 0);
      idle(1, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(5, 0);
      checkOutput("resetDiscard", 32'(Prescale), 32'd8);

      // Random traffic
      busyRun = 0;
      for (int i = 0; i < 3000; i++) begin
         int pres;
         bit wr, busy;
         if (busyRun > 0) busyRun--;
         else if ($urandom_range(0, 9) == 0) busyRun = $urandom_range(1, 12);
         busy = (busyRun > 0);
         wr = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 3))
            0: pres = 8;
            1: pres = 16;
            2: pres = 32;
            default: pres = $urandom_range(0, 63);
         endcase
         applyStimulus($urandom_range(0, 299) == 0, wr, pres, 1'($urandom), 1'($urandom), busy,
                       $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end
endmodule
